// File: rtl/voter_ballot_collector.sv
// Four-voter ballot front end: synchronises and debounces the raw buttons, collects
// sticky YES votes during a session, and latches the ballot when the session closes.
module voter_ballot_collector #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       close,
    input  logic [3:0] btn,
    output logic [3:0] votes,
    output logic [2:0] yes_count,
    output logic       result_valid,
    output logic       busy,
    output logic [3:0] voted
);

    localparam int unsigned NV    = 4;
    localparam int unsigned CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CLAST = DEBOUNCE_CYCLES - 1;
    localparam int unsigned TLAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [NV-1:0]            sync1_q, sync2_q;
    logic [NV-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [NV-1:0]            voted_q, voted_d;
    logic [NV-1:0]            votes_q, votes_d;
    logic [2:0]               yes_q, yes_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;

    // State and output registers; the synchroniser runs regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            voted_q <= '0;
            votes_q <= '0;
            yes_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            voted_q <= voted_d;
            votes_q <= votes_d;
            yes_q   <= yes_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    logic [NV-1:0] qual;
    logic [NV-1:0] ballot;
    logic          timeout_hit;

    // Next-state: debounce, timer, and ballot latch on the closing edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        voted_d     = voted_q;
        votes_d     = votes_q;
        yes_d       = yes_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        qual        = '0;
        ballot      = voted_q;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_OPEN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    timer_d = '0;
                    voted_d = '0;
                end
            end
            ST_OPEN: begin
                for (int k = 0; k < NV; k++) begin
                    if (!voted_q[k]) begin
                        if (sync2_q[k]) begin
                            if (cnt_q[k] == CW'(CLAST)) begin
                                qual[k] = 1'b1;
                            end else begin
                                cnt_d[k] = cnt_q[k] + CW'(1);
                            end
                        end else begin
                            cnt_d[k] = '0;
                        end
                    end
                end
                ballot  = voted_q | qual;
                voted_d = ballot;
                timeout_hit = (TIMEOUT > 0) && (timer_q == TW'(TLAST));
                if (timer_q != TW'(TLAST)) begin
                    timer_d = timer_q + TW'(1);
                end
                if (close || timeout_hit) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    votes_d = ballot;
                    yes_d   = 3'(ballot[0]) + 3'(ballot[1]) + 3'(ballot[2]) + 3'(ballot[3]);
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign votes        = votes_q;
    assign yes_count    = yes_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign voted        = voted_q;

endmodule

// File: tb/tb_voter_ballot_collector.sv
// Directed bench for voter_ballot_collector: a session-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_voter_ballot_collector;

    localparam int DEB = 4;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       close = 1'b0;
    logic [3:0] btn = 4'b0;

    logic [3:0] votes, voted, votes0, voted0;
    logic [2:0] yes_count, yes_count0;
    logic       result_valid, busy, result_valid0, busy0;

    int total = 0;
    int bad   = 0;

    voter_ballot_collector #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close), .btn(btn),
        .votes(votes), .yes_count(yes_count), .result_valid(result_valid),
        .busy(busy), .voted(voted)
    );

    voter_ballot_collector #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close), .btn(btn),
        .votes(votes0), .yes_count(yes_count0), .result_valid(result_valid0),
        .busy(busy0), .voted(voted0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Session model: buttons seen two edges late, votes after DEB consecutive highs.
    bit       m_open;
    bit [3:0] m_voted, m_votes, m_s1, m_s2, m_sb;
    int       m_run [4];
    int       m_age;
    int       m_cnt;
    bit       m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_voted = 0; m_votes = 0; m_s1 = 0; m_s2 = 0;
            m_age = 0; m_cnt = 0; m_valid = 0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            m_sb    = m_s2;
            m_valid = 0;
            if (m_open) begin
                m_age++;
                for (int k = 0; k < 4; k++) begin
                    if (!m_voted[k]) begin
                        m_run[k] = m_sb[k] ? m_run[k] + 1 : 0;
                        if (m_run[k] >= DEB) m_voted[k] = 1;
                    end
                end
                if (close || (TO > 0 && m_age == TO)) begin
                    m_votes = m_voted;
                    m_cnt   = $countones(m_voted);
                    m_valid = 1;
                    m_open  = 0;
                end
            end else if (start) begin
                m_open  = 1;
                m_voted = 0;
                m_age   = 0;
                for (int k = 0; k < 4; k++) m_run[k] = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    // Continuous comparison, sampled 2 time units after each active edge.
    always @(posedge clk) begin
        #2;
        check("busy",         32'(busy),         32'(m_open));
        check("voted",        32'(voted),        32'(m_voted));
        check("votes",        32'(votes),        32'(m_votes));
        check("yes_count",    32'(yes_count),    32'(m_cnt));
        check("result_valid", 32'(result_valid), 32'(m_valid));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_close();
        close = 1'b1; cyc(1); close = 1'b0;
    endtask

    // Count edges from the present point until result_valid, bounded.
    task automatic wait_valid(input int base, output int n);
        n = base;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            n++;
            if (result_valid) return;
        end
        n = -1;
    endtask

    int n;

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check("rst_votes", 32'(votes), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);

        // Basic ballot: 0111 held, close after 10 cycles.
        btn = 4'b0111;
        cyc(3);
        pulse_start();
        cyc(10);
        pulse_close();
        check("basic_votes", 32'(votes),        32'h7);
        check("basic_yes",   32'(yes_count),    32'd3);
        check("basic_valid", 32'(result_valid), 32'h1);
        check("basic_busy",  32'(busy),         32'h0);
        cyc(1);
        check("basic_pulse_len", 32'(result_valid), 32'h0);

        // Glitch rejection: btn[3] only three cycles high.
        btn = 4'b0000;
        cyc(3);
        pulse_start();
        btn = 4'b1001;
        cyc(3);
        btn = 4'b0001;
        cyc(8);
        pulse_close();
        check("glitch_votes", 32'(votes),     32'h1);
        check("glitch_yes",   32'(yes_count), 32'd1);

        // Timeout closes at E16; the TIMEOUT=0 instance stays open.
        btn = 4'b0010;
        cyc(3);
        pulse_start();
        wait_valid(0, n);
        check("timeout_edge",  32'(n),     32'd16);
        check("timeout_votes", 32'(votes), 32'h2);
        cyc(90);
        check("no_timeout_busy", 32'(busy0), 32'h1);

        // Sticky vote; a start while open must not restart the timer.
        btn = 4'b0100;
        cyc(3);
        pulse_start();
        cyc(6);
        btn = 4'b0000;
        cyc(2);
        check("sticky_voted", 32'(voted), 32'h4);
        pulse_start();
        wait_valid(9, n);
        check("sticky_edge",  32'(n),     32'd16);
        check("sticky_votes", 32'(votes), 32'h4);

        // Vote completing on the closing edge counts; old ballot holds while open.
        cyc(3);
        pulse_start();
        btn = 4'b0010;
        cyc(5);
        check("hold_votes", 32'(votes), 32'h4);
        check("pre_voted",  32'(voted), 32'h0);
        pulse_close();
        check("edge_votes", 32'(votes),        32'h2);
        check("edge_valid", 32'(result_valid), 32'h1);

        // Reset mid-session discards the session.
        btn = 4'b1111;
        cyc(2);
        pulse_start();
        cyc(8);
        rst_n = 1'b0;
        #1;
        check("arst_votes", 32'(votes),        32'h0);
        check("arst_voted", 32'(voted),        32'h0);
        check("arst_busy",  32'(busy),         32'h0);
        check("arst_valid", 32'(result_valid), 32'h0);
        check("arst_yes",   32'(yes_count),    32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        pulse_close();
        check("post_rst_valid", 32'(result_valid), 32'h0);
        check("post_rst_busy",  32'(busy),         32'h0);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
